// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 host transmit path.
// Holds the transmitter state encoding, the error codes reported on
// err_code and the keyboard command bytes most often sent by the host.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    ACK,
    WAIT_IDLE,
    DONE,
    ERR
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_NOACK   = 2'b10;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  // PS/2 frames carry odd parity: the parity bit makes the count of ones odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~(^data);
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: brings the raw PS/2 clock and data lines into the clk
// domain through two flops each and flags falling edges of the PS/2 clock.
// Lines idle high, so the flops reset to 1 to avoid a false edge after reset.
// Shared with the receive path.
module ps2_line_sync (
  input  logic clk,
  input  logic clrn,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_sync_o,
  output logic data_sync_o,
  output logic clk_fall_o
);

  logic [1:0] clk_meta_q;
  logic [1:0] data_meta_q;
  logic       clk_prev_q;

  // Two-stage synchroniser for both lines plus one delayed copy of the clock.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_meta_q  <= 2'b11;
      data_meta_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_meta_q  <= {clk_meta_q[0], ps2_clk_i};
      data_meta_q <= {data_meta_q[0], ps2_data_i};
      clk_prev_q  <= clk_meta_q[1];
    end
  end

  assign clk_sync_o  = clk_meta_q[1];
  assign data_sync_o = data_meta_q[1];
  assign clk_fall_o  = clk_prev_q & ~clk_meta_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter. Inhibits the bus, issues a
// request-to-send, shifts out data/parity/stop on device clock falls and
// checks the device ACK. Line drivers are active-high pull-low enables.
// Optional build macro PS2_TX_RETRY_EN: retry a failed byte up to two more
// times before reporting tx_err.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int REQ_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic [1:0] err_code,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int MAX_SETUP = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int MAX_CYC   = (MAX_SETUP > TIMEOUT_CYCLES) ? MAX_SETUP : TIMEOUT_CYCLES;
  localparam int CNT_W     = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] REQ_LAST = CNT_W'(REQ_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic [9:0]       shift_q, shift_d;
  logic             data_oe_q, data_oe_d;
  logic [1:0]       err_code_q, err_code_d;
`ifdef PS2_TX_RETRY_EN
  logic [1:0]       retry_q, retry_d;
`endif

  logic             clk_sync, data_sync, clk_fall;
  logic [CNT_W-1:0] cnt_inc;
  logic             timed_out;
  logic             fail;
  logic [1:0]       fail_code;

  ps2_line_sync u_sync (
    .clk         (clk),
    .clrn        (clrn),
    .ps2_clk_i   (ps2_clk_in),
    .ps2_data_i  (ps2_data_in),
    .clk_sync_o  (clk_sync),
    .data_sync_o (data_sync),
    .clk_fall_o  (clk_fall)
  );

  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  assign timed_out = (cnt_q >= TO_LAST);

  // Next-state logic: sequencing, bit shifting, timeout and failure routing.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    data_oe_d  = data_oe_q;
    err_code_d = err_code_q;
`ifdef PS2_TX_RETRY_EN
    retry_d    = retry_q;
`endif
    fail       = 1'b0;
    fail_code  = ERR_NONE;

    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          shift_d    = {1'b1, odd_parity(tx_data), tx_data};
          err_code_d = ERR_NONE;
          cnt_d      = '0;
          state_d    = INHIBIT;
`ifdef PS2_TX_RETRY_EN
          retry_d    = 2'd0;
`endif
        end
      end
      INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          cnt_d   = '0;
          state_d = REQ;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      REQ: begin
        if (cnt_q == REQ_LAST) begin
          cnt_d     = '0;
          idx_d     = 4'd0;
          data_oe_d = 1'b1;
          state_d   = SHIFT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      SHIFT: begin
        if (clk_fall) begin
          cnt_d = '0;
          if (idx_q == 4'd10) begin
            data_oe_d = 1'b0;
            state_d   = ACK;
          end else begin
            data_oe_d = ~shift_q[idx_q];
            idx_d     = idx_q + 4'd1;
          end
        end else if (timed_out) begin
          fail      = 1'b1;
          fail_code = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ACK: begin
        if (clk_fall) begin
          cnt_d = '0;
          if (!data_sync) begin
            state_d = WAIT_IDLE;
          end else begin
            fail      = 1'b1;
            fail_code = ERR_NOACK;
          end
        end else if (timed_out) begin
          fail      = 1'b1;
          fail_code = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WAIT_IDLE: begin
        if (clk_sync && data_sync) begin
          state_d = DONE;
        end else if (clk_fall) begin
          cnt_d = '0;
        end else if (timed_out) begin
          fail      = 1'b1;
          fail_code = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (fail) begin
      data_oe_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
      if (retry_q != 2'd2) begin
        retry_d = retry_q + 2'd1;
        cnt_d   = '0;
        state_d = INHIBIT;
      end else begin
        err_code_d = fail_code;
        state_d    = ERR;
      end
`else
      err_code_d = fail_code;
      state_d    = ERR;
`endif
    end
  end

  // State and datapath registers; reset returns to IDLE with lines released.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= 4'd0;
      shift_q    <= '0;
      data_oe_q  <= 1'b0;
      err_code_q <= ERR_NONE;
`ifdef PS2_TX_RETRY_EN
      retry_q    <= 2'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      data_oe_q  <= data_oe_d;
      err_code_q <= err_code_d;
`ifdef PS2_TX_RETRY_EN
      retry_q    <= retry_d;
`endif
    end
  end

  assign ps2_clk_oe  = (state_q == INHIBIT) || (state_q == REQ);
  assign ps2_data_oe = (state_q == REQ) || ((state_q == SHIFT) && data_oe_q);
  assign tx_ready    = (state_q == IDLE);
  assign tx_busy     = (state_q != IDLE);
  assign tx_done     = (state_q == DONE);
  assign tx_err      = (state_q == ERR);
  assign err_code    = err_code_q;

endmodule
